branch_resolver: RTL
====================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter PC_W, default 16, program counter width.
REQ-002 SHALL have parameter DISP_W, default 8, signed branch displacement width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port flag_we  input  1  latch szcv_in this cycle.
REQ-006 SHALL have port szcv_in  input  4  ALU flags {S,Z,C,V}, bit 3 = S.
REQ-007 SHALL have port br_valid  input  1  branch request valid.
REQ-008 SHALL have port br_ready  output  1  resolver can accept a request.
REQ-009 SHALL have port br_cond  input  3  condition code.
REQ-010 SHALL have port br_disp  input  DISP_W  signed displacement.
REQ-011 SHALL have port br_pc  input  PC_W  PC of the branch instruction.
REQ-012 SHALL have port redirect  output  1  taken-branch redirect request.
REQ-013 SHALL have port redirect_ack  input  1  fetch accepts the redirect.
REQ-014 SHALL have port target_pc  output  PC_W  redirect target.
REQ-015 SHALL have port not_taken  output  1  one-cycle pulse: branch resolved not taken.
REQ-016 SHALL have port flags  output  4  current flag register.
REQ-017 SHALL have port taken_cnt  output  16  saturating count of taken branches.

Function
REQ-018 SHALL implement FSM states IDLE, EVAL, REDIR.
REQ-019 SHALL drive br_ready = 1 only in IDLE; a transfer occurs when br_valid && br_ready.
REQ-020 On transfer SHALL register br_cond, br_disp and br_pc, then go to EVAL.
REQ-021 SHALL load the flag register from szcv_in on every cycle with flag_we = 1, in any state.
REQ-022 In EVAL SHALL evaluate the condition against the registered flags: a flag_we in the transfer cycle is visible; a flag_we in the EVAL cycle is not.
REQ-023 SHALL decode conditions as follows:
- 000: taken if Z.
- 001: taken if S^V.
- 010: taken if Z|(S^V).
- 011: taken if !Z.
- 100: always taken.
- 101-111: never taken.
REQ-024 SHALL compute target_pc = br_pc + 1 + sign-extended br_disp, truncated modulo 2^PC_W (wrap-around permitted, no error).
REQ-025 In EVAL, if taken, SHALL register target_pc, go to REDIR and increment taken_cnt, saturating at 0xFFFF.
REQ-026 In EVAL, if not taken, SHALL pulse not_taken for exactly that EVAL cycle and return to IDLE.
REQ-027 In REDIR SHALL hold redirect = 1 and target_pc stable until redirect_ack = 1, then return to IDLE the next cycle.
REQ-028 Minimum latency SHALL be: transfer at cycle N, not_taken at N+1, or redirect first asserted at N+2.
REQ-029 SHALL ignore redirect_ack outside REDIR.
REQ-030 SHALL ignore br_valid outside IDLE; requests are not queued.
REQ-031 redirect and not_taken SHALL never be asserted in the same cycle.

Reset
REQ-032 With rst_n = 0 at a clock edge, SHALL enter IDLE regardless of current state and abort any pending redirect.
REQ-033 Reset values SHALL be: flags = 0, taken_cnt = 0, target_pc = 0, redirect = 0, not_taken = 0, and br_ready = 1 from the first cycle after reset.
REQ-034 During reset, flag_we and br_valid SHALL have no effect.

Structure
REQ-035 The shared processor package SHALL hold:
- condition-code constants COND_BE, COND_BLT, COND_BLE, COND_BNE, COND_B;
- the flag bit-index constants FLAG_S, FLAG_Z, FLAG_C, FLAG_V;
- the FSM state enumeration.
REQ-036 The combinational condition decode SHALL be a sub-module cond_eval (inputs cond, szcv; output taken), reusable by other consumers of the ALU flags.

Verification
REQ-037 SHALL cover: flag_we with szcv_in = 0100, then br_cond = 000, br_pc = 0x0010, br_disp = 0x05 -> redirect at N+2 with target_pc = 0x0016 and taken_cnt = 1.
REQ-038 SHALL cover: flags = 1000 (S=1, V=0), br_cond = 001, br_disp = 0xFE, br_pc = 0x0001 -> target_pc = 0x0000; then with br_pc = 0x0000 -> target_pc = 0xFFFF (wrap).
REQ-039 SHALL cover: flags = 0100, br_cond = 011 -> not_taken pulse at N+1, redirect never asserted, br_ready = 1 at N+2.
REQ-040 SHALL cover: flag_we with szcv_in = 0100 in the same cycle as a br_cond = 000 transfer -> taken; flag_we with szcv_in = 0000 during EVAL -> still taken.
REQ-041 SHALL cover: redirect_ack held low 5 cycles -> redirect and target_pc stable for 5 cycles; br_valid during REDIR ignored.
REQ-042 SHALL cover: rst_n = 0 asserted in REDIR -> next cycle redirect = 0, flags = 0, taken_cnt = 0, br_ready = 1.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared processor definitions: condition codes, ALU flag bit positions and
// the branch resolver state encoding.
package branch_resolver_pkg;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;
  localparam logic [2:0] COND_B   = 3'b100;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch condition decode against an {S,Z,C,V} flag vector.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] szcv,
  output logic       taken
);

  // Carry is not consumed by any current condition code.
  logic unused_carry;
  assign unused_carry = szcv[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BE:  taken = szcv[FLAG_Z];
      COND_BLT: taken = szcv[FLAG_S] ^ szcv[FLAG_V];
      COND_BLE: taken = szcv[FLAG_Z] | (szcv[FLAG_S] ^ szcv[FLAG_V]);
      COND_BNE: taken = ~szcv[FLAG_Z];
      COND_B:   taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves one conditional PC-relative branch at a time: latch request,
// evaluate flags, then either pulse not_taken or hold a redirect until acked.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flag_we,
  input  logic [3:0]               szcv_in,
  input  logic                     br_valid,
  output logic                     br_ready,
  input  logic [2:0]               br_cond,
  input  logic signed [DISP_W-1:0] br_disp,
  input  logic [PC_W-1:0]          br_pc,
  output logic                     redirect,
  input  logic                     redirect_ack,
  output logic [PC_W-1:0]          target_pc,
  output logic                     not_taken,
  output logic [3:0]               flags,
  output logic [15:0]              taken_cnt
);

  br_state_t                state_q;
  logic                     ready_q;
  logic                     redirect_q;
  logic [3:0]               flags_q;
  logic [15:0]              cnt_q;
  logic [15:0]              cnt_d;
  logic [PC_W-1:0]          target_q;
  logic [PC_W-1:0]          target_d;
  logic [2:0]               cond_q;
  logic signed [DISP_W-1:0] disp_q;
  logic [PC_W-1:0]          pc_q;
  logic signed [PC_W-1:0]   disp_ext;
  logic                     taken;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .szcv  (flags_q),
    .taken (taken)
  );

  // Target wraps modulo 2^PC_W; no overflow detection is wanted.
  assign disp_ext = {{(PC_W-DISP_W){disp_q[DISP_W-1]}}, disp_q};
  assign target_d = pc_q + PC_W'(1) + disp_ext;
  assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Request payload carries no reset; it is only consumed after a transfer.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && br_valid) begin
      cond_q <= br_cond;
      disp_q <= br_disp;
      pc_q   <= br_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      redirect_q <= 1'b0;
      flags_q    <= 4'd0;
      cnt_q      <= 16'd0;
      target_q   <= '0;
    end else begin
      if (flag_we) flags_q <= szcv_in;
      case (state_q)
        IDLE: begin
          if (br_valid) begin
            state_q <= EVAL;
            ready_q <= 1'b0;
          end
        end
        EVAL: begin
          if (taken) begin
            state_q    <= REDIR;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            redirect_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        REDIR: begin
          if (redirect_ack) begin
            state_q    <= IDLE;
            redirect_q <= 1'b0;
            ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  assign br_ready  = ready_q;
  assign redirect  = redirect_q;
  assign target_pc = target_q;
  assign not_taken = (state_q == EVAL) && !taken;
  assign flags     = flags_q;
  assign taken_cnt = cnt_q;

endmodule
